// File: rtl/gpr_sb_file.sv
`default_nettype none
//============================================================================
// Module   : gpr_sb_file
// Purpose  : General-purpose register file. It has two registered read
//            ports, one write port and a per-register pending-write
//            scoreboard. A write in the same cycle as a read of the same
//            register is forwarded to that read. Each read result carries
//            a per-operand pending flag.
// Ports    : iCLK, iRST           - clock, synchronous active-high reset
//            iRD_EN, iRDREG0/1    - read request and operand addresses
//            iWR_EN, iWRREG, iDATA- writeback (clears pending)
//            iRSV_EN, iRSVREG     - destination reservation (sets pending)
//            oDATA0/1, oBUSY0/1   - registered read data and pending flags
//            oRD_VALID            - read results valid this cycle
//            oPEND                - live pending vector, bit n = register n
// Revision : 1.0 - initial release
//============================================================================
module gpr_sb_file #(
    parameter int                 WIDTH     = 12,
    parameter int                 ADDR_W    = 3,
    parameter int                 ZERO_REG  = 0,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic                    iCLK,
    input  logic                    iRST,
    input  logic                    iRD_EN,
    input  logic [ADDR_W-1:0]       iRDREG0,
    input  logic [ADDR_W-1:0]       iRDREG1,
    input  logic                    iWR_EN,
    input  logic [ADDR_W-1:0]       iWRREG,
    input  logic [WIDTH-1:0]        iDATA,
    input  logic                    iRSV_EN,
    input  logic [ADDR_W-1:0]       iRSVREG,
    output logic [WIDTH-1:0]        oDATA0,
    output logic [WIDTH-1:0]        oDATA1,
    output logic                    oRD_VALID,
    output logic                    oBUSY0,
    output logic                    oBUSY1,
    output logic [(2**ADDR_W)-1:0]  oPEND
);

    localparam int DEPTH = 2**ADDR_W;

    logic [WIDTH-1:0]        regs_q [DEPTH];
    logic [DEPTH-1:0]        pend_q, pend_d;
    logic [1:0][WIDTH-1:0]   rd_data_q, rd_data_d;
    logic [1:0]              rd_busy_q, rd_busy_d;
    logic                    rd_valid_q;
    logic [1:0][ADDR_W-1:0]  rd_addr;
    logic                    wr_ok;
    logic                    rsv_ok;

    // When register 0 is hardwired, writes and reservations to it are
    // discarded before they reach any state.
    assign wr_ok  = iWR_EN  && !((ZERO_REG != 0) && (iWRREG  == '0));
    assign rsv_ok = iRSV_EN && !((ZERO_REG != 0) && (iRSVREG == '0));

    assign rd_addr = {iRDREG1, iRDREG0};

    // The write clear is applied before the reservation. A write and a
    // reservation to the same register therefore leave it pending, because
    // the reservation belongs to a newer producer.
    always_comb begin
        pend_d = pend_q;
        if (wr_ok) begin
            pend_d[iWRREG] = 1'b0;
        end
        if (rsv_ok) begin
            pend_d[iRSVREG] = 1'b1;
        end
    end

    // A read observes the state after this cycle's write and before this
    // cycle's reservation. A forwarded operand therefore always reports
    // not-busy.
    for (genvar p = 0; p < 2; p++) begin : g_rd_port
        logic zero_hit;
        logic fwd_hit;

        assign zero_hit     = (ZERO_REG != 0) && (rd_addr[p] == '0);
        assign fwd_hit      = wr_ok && (iWRREG == rd_addr[p]);
        assign rd_data_d[p] = zero_hit ? '0   :
                              fwd_hit  ? iDATA : regs_q[rd_addr[p]];
        assign rd_busy_d[p] = zero_hit ? 1'b0 :
                              fwd_hit  ? 1'b0  : pend_q[rd_addr[p]];
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= RESET_VAL;
            end
            pend_q     <= '0;
            rd_data_q  <= '0;
            rd_busy_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            if (wr_ok) begin
                regs_q[iWRREG] <= iDATA;
            end
            pend_q     <= pend_d;
            rd_valid_q <= iRD_EN;
            // Read results are held while no read is requested.
            if (iRD_EN) begin
                rd_data_q <= rd_data_d;
                rd_busy_q <= rd_busy_d;
            end
        end
    end

    assign oDATA0    = rd_data_q[0];
    assign oDATA1    = rd_data_q[1];
    assign oBUSY0    = rd_busy_q[0];
    assign oBUSY1    = rd_busy_q[1];
    assign oRD_VALID = rd_valid_q;
    assign oPEND     = pend_q;

endmodule
`default_nettype wire

// File: tb/tb_gpr_sb_file.sv
`default_nettype none
//============================================================================
// Module   : tb_gpr_sb_file
// Purpose  : Directed self-checking bench for gpr_sb_file. It drives one
//            instance with ZERO_REG=0 and one with ZERO_REG=1 from the same
//            stimulus. Expected values are hand-computed constants.
// Revision : 1.0 - initial release
//============================================================================
module tb_gpr_sb_file;

    localparam int WIDTH  = 12;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 2**ADDR_W;

    logic              iCLK = 1'b0;
    logic              iRST, iRD_EN, iWR_EN, iRSV_EN;
    logic [ADDR_W-1:0] iRDREG0, iRDREG1, iWRREG, iRSVREG;
    logic [WIDTH-1:0]  iDATA;

    logic [WIDTH-1:0]  d0, d1, z_d0, z_d1;
    logic              vld, b0, b1, z_vld, z_b0, z_b1;
    logic [DEPTH-1:0]  pend, z_pend;

    int vectors    = 0;
    int miscompares = 0;

    always #5 iCLK = ~iCLK;

    gpr_sb_file #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .ZERO_REG(0), .RESET_VAL('0)) u_dut (
        .iCLK(iCLK), .iRST(iRST), .iRD_EN(iRD_EN), .iRDREG0(iRDREG0), .iRDREG1(iRDREG1),
        .iWR_EN(iWR_EN), .iWRREG(iWRREG), .iDATA(iDATA), .iRSV_EN(iRSV_EN), .iRSVREG(iRSVREG),
        .oDATA0(d0), .oDATA1(d1), .oRD_VALID(vld), .oBUSY0(b0), .oBUSY1(b1), .oPEND(pend)
    );

    gpr_sb_file #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .ZERO_REG(1), .RESET_VAL('0)) u_dut_z (
        .iCLK(iCLK), .iRST(iRST), .iRD_EN(iRD_EN), .iRDREG0(iRDREG0), .iRDREG1(iRDREG1),
        .iWR_EN(iWR_EN), .iWRREG(iWRREG), .iDATA(iDATA), .iRSV_EN(iRSV_EN), .iRSVREG(iRSVREG),
        .oDATA0(z_d0), .oDATA1(z_d1), .oRD_VALID(z_vld), .oBUSY0(z_b0), .oBUSY1(z_b1), .oPEND(z_pend)
    );

    // Advance one rising edge and settle #1 past it before sampling.
    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic idle();
        iRD_EN = 1'b0; iWR_EN = 1'b0; iRSV_EN = 1'b0;
        iRDREG0 = '0; iRDREG1 = '0; iWRREG = '0; iRSVREG = '0; iDATA = '0;
    endtask

    task automatic test_reset();
        idle(); iRST = 1'b1;
        tick();
        vectors++; if (vld !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", vld); end
        vectors++; if (pend !== 8'h00) begin miscompares++; $display("FAIL reset_pend: got %h expected 00", pend); end
        vectors++; if (d0 !== 12'h000 || d1 !== 12'h000) begin miscompares++; $display("FAIL reset_data: got %h/%h expected 000/000", d0, d1); end
        iRST = 1'b0;
        iRD_EN = 1'b1; iRDREG0 = 3'd3; iRDREG1 = 3'd7;
        tick();
        vectors++; if (vld !== 1'b1) begin miscompares++; $display("FAIL first_read_valid: got %b expected 1", vld); end
        vectors++; if (d0 !== 12'h000 || d1 !== 12'h000) begin miscompares++; $display("FAIL first_read_data: got %h/%h expected 000/000", d0, d1); end
        vectors++; if (b0 !== 1'b0 || b1 !== 1'b0) begin miscompares++; $display("FAIL first_read_busy: got %b/%b expected 0/0", b0, b1); end
        vectors++; if (pend !== 8'h00) begin miscompares++; $display("FAIL first_read_pend: got %h expected 00", pend); end
        idle();
    endtask

    task automatic test_write_read();
        iWR_EN = 1'b1; iWRREG = 3'd5; iDATA = 12'hA5A;
        tick();
        vectors++; if (vld !== 1'b0) begin miscompares++; $display("FAIL no_read_valid: got %b expected 0", vld); end
        idle(); iRD_EN = 1'b1; iRDREG0 = 3'd5; iRDREG1 = 3'd5;
        tick();
        vectors++; if (d0 !== 12'hA5A || d1 !== 12'hA5A) begin miscompares++; $display("FAIL wr_rd_data: got %h/%h expected A5A/A5A", d0, d1); end
        vectors++; if (b0 !== 1'b0 || b1 !== 1'b0 || vld !== 1'b1) begin miscompares++; $display("FAIL wr_rd_flags: got busy %b/%b valid %b expected 0/0 valid 1", b0, b1, vld); end
        idle(); iRDREG0 = 3'd3;
        tick();
        vectors++; if (vld !== 1'b0 || d0 !== 12'hA5A) begin miscompares++; $display("FAIL hold: got valid %b data %h expected valid 0 data A5A", vld, d0); end
    endtask

    task automatic test_reserve();
        idle(); iRSV_EN = 1'b1; iRSVREG = 3'd2;
        tick();
        vectors++; if (pend !== 8'h04) begin miscompares++; $display("FAIL rsv_pend: got %h expected 04", pend); end
        idle(); iRD_EN = 1'b1; iRDREG0 = 3'd2; iRDREG1 = 3'd5;
        tick();
        vectors++; if (b0 !== 1'b1 || b1 !== 1'b0) begin miscompares++; $display("FAIL rsv_busy: got %b/%b expected 1/0", b0, b1); end
        idle(); iRD_EN = 1'b1; iRDREG0 = 3'd2; iRDREG1 = 3'd2;
        iWR_EN = 1'b1; iWRREG = 3'd2; iDATA = 12'h123;
        tick();
        vectors++; if (d0 !== 12'h123 || d1 !== 12'h123) begin miscompares++; $display("FAIL fwd_data: got %h/%h expected 123/123", d0, d1); end
        vectors++; if (b0 !== 1'b0 || pend !== 8'h00) begin miscompares++; $display("FAIL fwd_clear: got busy %b pend %h expected 0 pend 00", b0, pend); end
        idle();
    endtask

    task automatic test_wr_rsv_same();
        iRD_EN = 1'b1; iRDREG0 = 3'd4; iRDREG1 = 3'd4;
        iWR_EN = 1'b1; iWRREG = 3'd4; iDATA = 12'h0FF;
        iRSV_EN = 1'b1; iRSVREG = 3'd4;
        tick();
        vectors++; if (d0 !== 12'h0FF || b0 !== 1'b0 || b1 !== 1'b0) begin miscompares++; $display("FAIL wrrsv_read: got %h busy %b/%b expected 0FF busy 0/0", d0, b0, b1); end
        vectors++; if (pend !== 8'h10) begin miscompares++; $display("FAIL wrrsv_pend: got %h expected 10", pend); end
        idle(); iRD_EN = 1'b1; iRDREG0 = 3'd4; iRDREG1 = 3'd4;
        tick();
        vectors++; if (d0 !== 12'h0FF || b0 !== 1'b1 || b1 !== 1'b1) begin miscompares++; $display("FAIL wrrsv_later: got %h busy %b/%b expected 0FF busy 1/1", d0, b0, b1); end
        idle(); iWR_EN = 1'b1; iWRREG = 3'd4; iDATA = 12'h0FF;
        tick();
        vectors++; if (pend !== 8'h00) begin miscompares++; $display("FAIL wrrsv_clear: got %h expected 00", pend); end
        idle();
    endtask

    task automatic test_zero_reg();
        iRD_EN = 1'b1; iRDREG0 = 3'd0; iRDREG1 = 3'd0;
        iWR_EN = 1'b1; iWRREG = 3'd0; iDATA = 12'hFFF;
        tick();
        vectors++; if (z_d0 !== 12'h000 || z_d1 !== 12'h000 || z_b0 !== 1'b0) begin miscompares++; $display("FAIL zero_fwd: got %h/%h busy %b expected 000/000 busy 0", z_d0, z_d1, z_b0); end
        vectors++; if (d0 !== 12'hFFF) begin miscompares++; $display("FAIL nozero_fwd: got %h expected FFF", d0); end
        idle(); iRSV_EN = 1'b1; iRSVREG = 3'd0;
        tick();
        vectors++; if (z_pend !== 8'h00) begin miscompares++; $display("FAIL zero_rsv_pend: got %h expected 00", z_pend); end
        vectors++; if (pend !== 8'h01) begin miscompares++; $display("FAIL nozero_rsv_pend: got %h expected 01", pend); end
        idle(); iRD_EN = 1'b1; iRDREG0 = 3'd0; iRDREG1 = 3'd0;
        tick();
        vectors++; if (z_d0 !== 12'h000 || z_b0 !== 1'b0 || z_b1 !== 1'b0) begin miscompares++; $display("FAIL zero_read: got %h busy %b/%b expected 000 busy 0/0", z_d0, z_b0, z_b1); end
        vectors++; if (d0 !== 12'hFFF || b0 !== 1'b1) begin miscompares++; $display("FAIL nozero_read: got %h busy %b expected FFF busy 1", d0, b0); end
        idle(); iWR_EN = 1'b1; iWRREG = 3'd0; iDATA = 12'h001;
        tick();
        vectors++; if (pend !== 8'h00) begin miscompares++; $display("FAIL nozero_clear: got %h expected 00", pend); end
        idle();
    endtask

    task automatic test_dual_port();
        iRD_EN = 1'b1; iRDREG0 = 3'd5; iRDREG1 = 3'd4;
        tick();
        vectors++; if (d0 !== 12'hA5A || d1 !== 12'h0FF) begin miscompares++; $display("FAIL dual_data: got %h/%h expected A5A/0FF", d0, d1); end
        vectors++; if (z_d0 !== 12'hA5A || z_d1 !== 12'h0FF || z_vld !== 1'b1) begin miscompares++; $display("FAIL dual_data_z: got %h/%h valid %b expected A5A/0FF valid 1", z_d0, z_d1, z_vld); end
        idle();
    endtask

    task automatic test_mid_reset();
        iRSV_EN = 1'b1; iRSVREG = 3'd1;
        tick();
        idle(); iRSV_EN = 1'b1; iRSVREG = 3'd6;
        iWR_EN = 1'b1; iWRREG = 3'd3; iDATA = 12'h777;
        tick();
        vectors++; if (pend !== 8'h42) begin miscompares++; $display("FAIL pre_rst_pend: got %h expected 42", pend); end
        idle(); iRST = 1'b1; iRD_EN = 1'b1; iRDREG0 = 3'd3; iRDREG1 = 3'd3;
        tick();
        vectors++; if (vld !== 1'b0 || z_vld !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b/%b expected 0/0", vld, z_vld); end
        vectors++; if (pend !== 8'h00 || z_pend !== 8'h00) begin miscompares++; $display("FAIL rst_pend: got %h/%h expected 00/00", pend, z_pend); end
        iRST = 1'b0; iRDREG0 = 3'd3; iRDREG1 = 3'd5;
        tick();
        vectors++; if (vld !== 1'b1 || d0 !== 12'h000 || d1 !== 12'h000) begin miscompares++; $display("FAIL post_rst_read: got valid %b data %h/%h expected valid 1 data 000/000", vld, d0, d1); end
        idle();
    endtask

    initial begin
        iRST = 1'b1;
        idle();
        test_reset();
        test_write_read();
        test_reserve();
        test_wr_rsv_same();
        test_zero_reg();
        test_dual_port();
        test_mid_reset();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
